// File: rtl/mem_pipe_if.sv
// Exec-side issue handshake and writeback-side result handshake of the memory-access stage.
// master = exec/writeback environment, slave = mem_pipe.
interface mem_pipe_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 17,
    parameter int REG_W  = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_op;
    logic [ADDR_W-1:0] in_addr;
    logic [DATA_W-1:0] in_wdata;
    logic [DATA_W-1:0] in_tdata;
    logic [REG_W-1:0]  in_rt;
    logic              in_rt_flag;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_tdata;
    logic [REG_W-1:0]  out_rt;
    logic              out_rt_flag;

    modport master (
        output in_valid, in_op, in_addr, in_wdata, in_tdata, in_rt, in_rt_flag,
        input  in_ready,
        input  out_valid, out_tdata, out_rt, out_rt_flag,
        output out_ready
    );

    modport slave (
        input  in_valid, in_op, in_addr, in_wdata, in_tdata, in_rt, in_rt_flag,
        output in_ready,
        output out_valid, out_tdata, out_rt, out_rt_flag,
        input  out_ready
    );
endinterface

// File: rtl/mem_pipe.sv
// Memory-access stage: issues loads/stores to a fixed-latency RAM and carries every op through
// a never-stalling delay line into a credit-protected output FIFO so writeback keeps issue order.
module mem_pipe #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 17,
    parameter int REG_W  = 5,
    parameter int RD_LAT = 2,
    parameter int FIFO_D = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    mem_pipe_if.slave             bus,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic [(2**REG_W)-1:0] pending_mask
);
    localparam int NREG  = 2**REG_W;
    localparam int PTR_W = $clog2(FIFO_D);
    localparam int CNT_W = $clog2(FIFO_D + 1);
    localparam int OUT_W = $clog2(RD_LAT + FIFO_D + 1);
    localparam int LAST  = RD_LAT - 1;

    logic              run;
    logic              fire;
    logic              op_load;
    logic              op_store;

    logic              dl_valid [RD_LAT];
    logic              dl_load  [RD_LAT];
    logic              dl_store [RD_LAT];
    logic [DATA_W-1:0] dl_tdata [RD_LAT];
    logic [REG_W-1:0]  dl_rt    [RD_LAT];
    logic              dl_flag  [RD_LAT];

    logic [DATA_W-1:0] f_data [FIFO_D];
    logic [REG_W-1:0]  f_rt   [FIFO_D];
    logic              f_flag [FIFO_D];
    logic              f_vld  [FIFO_D];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;

    logic              push;
    logic              pop;
    logic [DATA_W-1:0] push_data;
    logic [OUT_W-1:0]  outstanding;
    logic [NREG-1:0]   pm;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_D - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // 11 decodes as pass: only 01 and 10 touch the RAM.
    assign op_load  = (bus.in_op == 2'b01);
    assign op_store = (bus.in_op == 2'b10);
    assign fire     = bus.in_valid && bus.in_ready;

    assign mem_en    = fire && (op_load || op_store);
    assign mem_we    = fire && op_store;
    assign mem_addr  = bus.in_addr;
    assign mem_wdata = bus.in_wdata;

    // Each non-store op in flight holds a reserved FIFO slot, so the FIFO cannot overflow.
    always_comb begin
        outstanding = OUT_W'(count);
        for (int k = 0; k < RD_LAT; k++) begin
            if (dl_valid[k] && !dl_store[k]) outstanding = outstanding + OUT_W'(1);
        end
    end

    assign bus.in_ready = rstn && run && (outstanding < OUT_W'(FIFO_D));

    assign push      = dl_valid[LAST] && !dl_store[LAST];
    assign push_data = dl_load[LAST] ? mem_rdata : dl_tdata[LAST];
    assign pop       = bus.out_valid && bus.out_ready;

    assign bus.out_valid   = rstn && (count != '0);
    assign bus.out_tdata   = bus.out_valid ? f_data[rd_ptr] : '0;
    assign bus.out_rt      = bus.out_valid ? f_rt[rd_ptr]   : '0;
    assign bus.out_rt_flag = bus.out_valid ? f_flag[rd_ptr] : 1'b0;

    always_comb begin
        pm = '0;
        for (int k = 0; k < RD_LAT; k++) begin
            if (dl_valid[k] && dl_flag[k]) pm[dl_rt[k]] = 1'b1;
        end
        for (int i = 0; i < FIFO_D; i++) begin
            if (f_vld[i] && f_flag[i]) pm[f_rt[i]] = 1'b1;
        end
        pending_mask = rstn ? pm : '0;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            run <= 1'b0;
            for (int k = 0; k < RD_LAT; k++) dl_valid[k] <= 1'b0;
        end else begin
            run         <= 1'b1;
            dl_valid[0] <= fire;
            for (int k = 1; k < RD_LAT; k++) dl_valid[k] <= dl_valid[k-1];
        end
    end

    always_ff @(posedge clk) begin
        dl_load[0]  <= op_load;
        dl_store[0] <= op_store;
        dl_tdata[0] <= bus.in_tdata;
        dl_rt[0]    <= bus.in_rt;
        dl_flag[0]  <= bus.in_rt_flag;
        for (int k = 1; k < RD_LAT; k++) begin
            dl_load[k]  <= dl_load[k-1];
            dl_store[k] <= dl_store[k-1];
            dl_tdata[k] <= dl_tdata[k-1];
            dl_rt[k]    <= dl_rt[k-1];
            dl_flag[k]  <= dl_flag[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_D; i++) f_vld[i] <= 1'b0;
        end else begin
            // Clear before set: when full, a simultaneous push and pop share one slot.
            if (pop) begin
                f_vld[rd_ptr] <= 1'b0;
                rd_ptr        <= ptr_inc(rd_ptr);
            end
            if (push) begin
                f_vld[wr_ptr] <= 1'b1;
                wr_ptr        <= ptr_inc(wr_ptr);
            end
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (!push && pop) count <= count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            f_data[wr_ptr] <= push_data;
            f_rt[wr_ptr]   <= dl_rt[LAST];
            f_flag[wr_ptr] <= dl_flag[LAST];
        end
    end
endmodule

// File: tb/tb_mem_pipe.sv
// Directed bench for mem_pipe with a 2-cycle synchronous RAM model and an output recorder.
module tb_mem_pipe;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 17;
    localparam int REG_W  = 5;
    localparam int RD_LAT = 2;
    localparam int FIFO_D = 4;

    localparam logic [1:0] OP_PASS  = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    mem_pipe_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_W(REG_W)) bus ();

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [31:0]       pending_mask;

    mem_pipe #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_W(REG_W), .RD_LAT(RD_LAT), .FIFO_D(FIFO_D)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .bus(bus),
        .mem_en(mem_en),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .pending_mask(pending_mask)
    );

    // RAM model: read issued in cycle t shows on mem_rdata in cycle t+2.
    logic [31:0] ram [256];
    logic [31:0] rd1 = '0;
    logic [31:0] rd2 = '0;
    logic        ram_init = 1'b0;
    always @(posedge clk) begin
        if (!ram_init) begin
            for (int i = 0; i < 256; i++) ram[i] <= 32'h0;
            ram[8'h10] <= 32'hDEADBEEF;
            ram_init   <= 1'b1;
        end else if (mem_en && mem_we) begin
            ram[mem_addr[7:0]] <= mem_wdata;
        end
        if (mem_en && !mem_we) rd1 <= ram[mem_addr[7:0]];
        rd2 <= rd1;
    end
    assign mem_rdata = rd2;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          q_cyc  [$];
    logic [31:0] q_data [$];
    logic [4:0]  q_rt   [$];
    always @(negedge clk) begin
        if (bus.out_valid && bus.out_ready) begin
            q_cyc.push_back(cyc);
            q_data.push_back(bus.out_tdata);
            q_rt.push_back(bus.out_rt);
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [ADDR_W-1:0] addr,
                         input logic [31:0] wd, input logic [31:0] td,
                         input logic [4:0] rt, input logic fl);
        bus.in_valid   = v;
        bus.in_op      = op;
        bus.in_addr    = addr;
        bus.in_wdata   = wd;
        bus.in_tdata   = td;
        bus.in_rt      = rt;
        bus.in_rt_flag = fl;
    endtask

    task automatic idle();
        drive(1'b0, OP_PASS, '0, 32'h0, 32'h0, 5'd0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int base;
        logic [31:0] exp_ord [3];
        logic [4:0]  exp_rt  [3];
        exp_ord = '{32'h5, 32'hDEADBEEF, 32'h7};
        exp_rt  = '{5'd1, 5'd2, 5'd4};

        bus.out_ready = 1'b1;
        drive(1'b1, OP_LOAD, 17'h10, 32'h0, 32'h0, 5'd3, 1'b1);

        // Reset held with an op offered.
        repeat (3) begin
            next();
            #1;
            check("rst_in_ready", bus.in_ready, 0);
            check("rst_mem_en", mem_en, 0);
            check("rst_mem_we", mem_we, 0);
            check("rst_out_valid", bus.out_valid, 0);
            check("rst_pending", pending_mask, 0);
            check("rst_out_tdata", bus.out_tdata, 0);
        end
        rstn = 1'b1;
        idle();
        next();
        #1;
        check("rel_in_ready", bus.in_ready, 1);

        // Load latency.
        drive(1'b1, OP_LOAD, 17'h10, 32'h0, 32'h0, 5'd3, 1'b1);
        #1;
        check("ld_mem_en", mem_en, 1);
        check("ld_mem_we", mem_we, 0);
        check("ld_mem_addr", mem_addr, 17'h10);
        check("ld_pending_t", pending_mask, 0);
        next();
        idle();
        #1;
        check("ld_pending_t1", pending_mask, 32'h8);
        check("ld_out_valid_t1", bus.out_valid, 0);
        next();
        #1;
        check("ld_out_valid_t2", bus.out_valid, 0);
        check("ld_pending_t2", pending_mask, 32'h8);
        next();
        #1;
        check("ld_out_valid_t3", bus.out_valid, 1);
        check("ld_out_tdata", bus.out_tdata, 32'hDEADBEEF);
        check("ld_out_rt", bus.out_rt, 3);
        check("ld_out_flag", bus.out_rt_flag, 1);
        next();
        #1;
        check("ld_out_valid_t4", bus.out_valid, 0);
        check("ld_pending_t4", pending_mask, 0);

        // Back-to-back ordering, one result per cycle.
        base = q_data.size();
        t0   = cyc;
        drive(1'b1, OP_PASS, 17'h0, 32'h0, 32'h5, 5'd1, 1'b1);
        next();
        drive(1'b1, OP_LOAD, 17'h10, 32'h0, 32'h0, 5'd2, 1'b1);
        next();
        drive(1'b1, OP_PASS, 17'h0, 32'h0, 32'h7, 5'd4, 1'b1);
        next();
        idle();
        repeat (6) next();
        check("ord_count", q_data.size() - base, 3);
        for (int i = 0; i < 3; i++) begin
            if (base + i < q_data.size()) begin
                check($sformatf("ord_data%0d", i), q_data[base+i], exp_ord[i]);
                check($sformatf("ord_rt%0d", i), q_rt[base+i], exp_rt[i]);
                check($sformatf("ord_cyc%0d", i), q_cyc[base+i], t0 + 3 + i);
            end
        end

        // Reserved op encoding behaves as pass.
        base = q_data.size();
        drive(1'b1, OP_RSVD, 17'h10, 32'h0, 32'h77, 5'd5, 1'b1);
        #1;
        check("rsvd_mem_en", mem_en, 0);
        next();
        idle();
        repeat (5) next();
        check("rsvd_count", q_data.size() - base, 1);
        if (base < q_data.size()) begin
            check("rsvd_data", q_data[base], 32'h77);
            check("rsvd_rt", q_rt[base], 5);
        end

        // Store then load of the same address.
        base = q_data.size();
        drive(1'b1, OP_STORE, 17'h20, 32'h1234, 32'h0, 5'd0, 1'b0);
        #1;
        check("st_mem_en", mem_en, 1);
        check("st_mem_we", mem_we, 1);
        check("st_mem_addr", mem_addr, 17'h20);
        check("st_mem_wdata", mem_wdata, 32'h1234);
        next();
        drive(1'b1, OP_LOAD, 17'h20, 32'h0, 32'h0, 5'd6, 1'b1);
        next();
        idle();
        repeat (6) next();
        check("st_count", q_data.size() - base, 1);
        if (base < q_data.size()) begin
            check("st_ld_data", q_data[base], 32'h1234);
            check("st_ld_rt", q_rt[base], 6);
        end

        // Backpressure: exactly FIFO_D accepted while out_ready is low.
        base = q_data.size();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, OP_PASS, 17'h0, 32'h0, 32'h100 + i, 5'(8 + i), 1'b1);
            #1;
            check($sformatf("bp_in_ready%0d", i), bus.in_ready, (i < FIFO_D) ? 1 : 0);
            next();
        end
        idle();
        #1;
        check("bp_pending", pending_mask, 32'h0000_0F00);
        check("bp_out_valid", bus.out_valid, 1);
        check("bp_no_pop", q_data.size() - base, 0);
        bus.out_ready = 1'b1;
        repeat (8) next();
        check("bp_count", q_data.size() - base, 4);
        for (int i = 0; i < 4; i++) begin
            if (base + i < q_data.size())
                check($sformatf("bp_data%0d", i), q_data[base+i], 32'h100 + i);
        end
        check("bp_in_ready_after", bus.in_ready, 1);
        check("bp_pending_after", pending_mask, 0);

        // Reset while loads are in flight.
        base = q_data.size();
        drive(1'b1, OP_LOAD, 17'h10, 32'h0, 32'h0, 5'd1, 1'b1);
        next();
        drive(1'b1, OP_LOAD, 17'h20, 32'h0, 32'h0, 5'd2, 1'b1);
        next();
        idle();
        rstn = 1'b0;
        #1;
        check("mid_rst_pending", pending_mask, 0);
        check("mid_rst_in_ready", bus.in_ready, 0);
        check("mid_rst_out_valid", bus.out_valid, 0);
        next();
        rstn = 1'b1;
        #1;
        check("mid_rel_out_valid", bus.out_valid, 0);
        check("mid_rel_pending", pending_mask, 0);
        next();
        #1;
        check("mid_rel_in_ready", bus.in_ready, 1);
        drive(1'b1, OP_PASS, 17'h0, 32'h0, 32'hABC, 5'd9, 1'b1);
        next();
        idle();
        repeat (6) next();
        check("mid_count", q_data.size() - base, 1);
        if (base < q_data.size()) begin
            check("mid_data", q_data[base], 32'hABC);
            check("mid_rt", q_rt[base], 9);
        end
        check("mid_pending_end", pending_mask, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
